// File: rtl/finish_overlay_mixer_if.sv
//==============================================================================
// Module : finish_overlay_mixer_if
// Brief  : Pixel, sync and game-control bundle feeding the finish overlay mixer.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface finish_overlay_mixer_if;
    logic       i_v_sync;
    logic       i_de;
    logic [7:0] i_bg_red;
    logic [7:0] i_bg_green;
    logic [7:0] i_bg_blue;
    logic [7:0] i_game_red;
    logic [7:0] i_game_green;
    logic [7:0] i_game_blue;
    logic       i_game_hit;
    logic [7:0] i_label_red;
    logic [7:0] i_label_green;
    logic [7:0] i_label_blue;
    logic       i_label_hit;
    logic       i_finish;
    logic       i_restart;
    logic [7:0] o_red;
    logic [7:0] o_green;
    logic [7:0] o_blue;
    logic       o_finished;
    logic       o_label_on;

    modport slave (
        input  i_v_sync, i_de,
        input  i_bg_red, i_bg_green, i_bg_blue,
        input  i_game_red, i_game_green, i_game_blue, i_game_hit,
        input  i_label_red, i_label_green, i_label_blue, i_label_hit,
        input  i_finish, i_restart,
        output o_red, o_green, o_blue, o_finished, o_label_on
    );

    modport master (
        output i_v_sync, i_de,
        output i_bg_red, i_bg_green, i_bg_blue,
        output i_game_red, i_game_green, i_game_blue, i_game_hit,
        output i_label_red, i_label_green, i_label_blue, i_label_hit,
        output i_finish, i_restart,
        input  o_red, o_green, o_blue, o_finished, o_label_on
    );
endinterface

`default_nettype wire

// File: rtl/finish_overlay_mixer.sv
//==============================================================================
// Module : finish_overlay_mixer
// Brief  : Label > game > background pixel mixer with end-of-game blink/hold overlay.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module finish_overlay_mixer #(
    parameter int BLINK_FRAMES  = 4,
    parameter int BLINK_TOGGLES = 6,
    parameter int DIM_SHIFT     = 1
) (
    input  wire                     i_clk,
    input  wire                     i_rst,
    finish_overlay_mixer_if.slave   bus
);

    localparam logic [7:0] C_FRAME_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] C_TOGGLES    = 8'(BLINK_TOGGLES);
    localparam logic [2:0] C_DIM        = 3'(DIM_SHIFT);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        BLINK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     r_state,     w_state_nxt;
    logic       r_label_on,  w_label_on_nxt;
    logic [7:0] r_frame_cnt, w_frame_cnt_nxt;
    logic [7:0] r_tog_cnt,   w_tog_cnt_nxt;
    logic       r_v_sync_q;
    logic       r_finished;
    logic [7:0] r_red, r_green, r_blue;

    logic       w_tick;
    logic [7:0] w_tog_inc;
    logic [2:0] w_shift;
    logic [7:0] w_red, w_green, w_blue;

    assign w_tick    = bus.i_v_sync & ~r_v_sync_q;
    assign w_tog_inc = r_tog_cnt + 8'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= PLAY;
            r_label_on  <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_tog_cnt   <= 8'd0;
            r_v_sync_q  <= 1'b0;
            r_finished  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_label_on  <= w_label_on_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_tog_cnt   <= w_tog_cnt_nxt;
            r_v_sync_q  <= bus.i_v_sync;
            r_finished  <= (w_state_nxt != PLAY);
        end
    end

    // Restart outranks both finish and frame tick in every state.
    always_comb begin
        w_state_nxt     = r_state;
        w_label_on_nxt  = r_label_on;
        w_frame_cnt_nxt = r_frame_cnt;
        w_tog_cnt_nxt   = r_tog_cnt;
        case (r_state)
            PLAY: begin
                w_label_on_nxt = 1'b0;
                if (!bus.i_restart && bus.i_finish) begin
                    w_state_nxt     = BLINK;
                    w_label_on_nxt  = 1'b1;
                    w_frame_cnt_nxt = 8'd0;
                    w_tog_cnt_nxt   = 8'd0;
                end
            end
            BLINK: begin
                if (bus.i_restart) begin
                    w_state_nxt    = PLAY;
                    w_label_on_nxt = 1'b0;
                end else if (w_tick) begin
                    if (r_frame_cnt == C_FRAME_LAST) begin
                        w_label_on_nxt  = ~r_label_on;
                        w_frame_cnt_nxt = 8'd0;
                        w_tog_cnt_nxt   = w_tog_inc;
                        if (w_tog_inc == C_TOGGLES) begin
                            w_state_nxt    = HOLD;
                            w_label_on_nxt = 1'b1;
                        end
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                    end
                end
            end
            HOLD: begin
                w_label_on_nxt = 1'b1;
                if (bus.i_restart) begin
                    w_state_nxt    = PLAY;
                    w_label_on_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = PLAY;
                w_label_on_nxt = 1'b0;
            end
        endcase
    end

    // Hit bits gate every mux leg so unknown values on unselected sources never reach the output.
    assign w_shift = r_finished ? C_DIM : 3'd0;

    always_comb begin
        w_red   = 8'd0;
        w_green = 8'd0;
        w_blue  = 8'd0;
        if (bus.i_de) begin
            if (r_label_on && bus.i_label_hit) begin
                w_red   = bus.i_label_red;
                w_green = bus.i_label_green;
                w_blue  = bus.i_label_blue;
            end else if (bus.i_game_hit) begin
                w_red   = bus.i_game_red   >> w_shift;
                w_green = bus.i_game_green >> w_shift;
                w_blue  = bus.i_game_blue  >> w_shift;
            end else begin
                w_red   = bus.i_bg_red     >> w_shift;
                w_green = bus.i_bg_green   >> w_shift;
                w_blue  = bus.i_bg_blue    >> w_shift;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_red   <= 8'd0;
            r_green <= 8'd0;
            r_blue  <= 8'd0;
        end else begin
            r_red   <= w_red;
            r_green <= w_green;
            r_blue  <= w_blue;
        end
    end

    assign bus.o_red      = r_red;
    assign bus.o_green    = r_green;
    assign bus.o_blue     = r_blue;
    assign bus.o_finished = r_finished;
    assign bus.o_label_on = r_label_on;

endmodule

`default_nettype wire

// File: tb/tb_finish_overlay_mixer.sv
//==============================================================================
// Module : tb_finish_overlay_mixer
// Brief  : Randomised and directed bench for finish_overlay_mixer.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_finish_overlay_mixer;

    localparam int BF = 4;
    localparam int BT = 6;
    localparam int DS = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    finish_overlay_mixer_if bus();

    finish_overlay_mixer #(
        .BLINK_FRAMES (BF),
        .BLINK_TOGGLES(BT),
        .DIM_SHIFT    (DS)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic        fin;
        logic        lab;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Stimulus for the next cycle
    logic        s_rst, s_de, s_vs, s_ghit, s_lhit, s_fin, s_rs;
    logic [23:0] s_bg, s_game, s_label;

    // Reference model: "finished" flag plus frame ticks counted since finish
    bit m_fin;
    int m_ticks;
    bit m_vsq;

    function automatic bit m_label();
        if (!m_fin) return 1'b0;
        if (m_ticks >= BF * BT) return 1'b1;
        return ((m_ticks / BF) % 2) == 0;
    endfunction

    function automatic logic [23:0] m_dim(input logic [23:0] c);
        if (!m_fin) return c;
        return {c[23:16] >> DS, c[15:8] >> DS, c[7:0] >> DS};
    endfunction

    task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic apply();
        exp_t e;
        bit   tick;
        @(negedge clk);
        rst               = s_rst;
        bus.i_de          = s_de;
        bus.i_v_sync      = s_vs;
        {bus.i_bg_red, bus.i_bg_green, bus.i_bg_blue}          = s_bg;
        {bus.i_game_red, bus.i_game_green, bus.i_game_blue}    = s_game;
        {bus.i_label_red, bus.i_label_green, bus.i_label_blue} = s_label;
        bus.i_game_hit    = s_ghit;
        bus.i_label_hit   = s_lhit;
        bus.i_finish      = s_fin;
        bus.i_restart     = s_rs;

        tick = s_vs && !m_vsq;
        if (s_rst)                  e.rgb = 24'h0;
        else if (!s_de)             e.rgb = 24'h0;
        else if (m_label() && s_lhit) e.rgb = s_label;
        else if (s_ghit)            e.rgb = m_dim(s_game);
        else                        e.rgb = m_dim(s_bg);

        if (s_rst) begin
            m_fin = 0; m_ticks = 0; m_vsq = 0;
        end else begin
            m_vsq = s_vs;
            if (s_rs) m_fin = 0;
            else if (!m_fin && s_fin) begin
                m_fin = 1; m_ticks = 0;
            end else if (m_fin && tick && m_ticks < BF * BT) m_ticks++;
        end
        e.fin = m_fin;
        e.lab = m_label();
        q.push_back(e);
    endtask

    task automatic rand_pix();
        s_bg    = 24'($urandom);
        s_game  = 24'($urandom);
        s_label = 24'($urandom);
        s_ghit  = 1'($urandom);
        s_lhit  = 1'($urandom);
        s_de    = ($urandom % 8) != 0;
    endtask

    task automatic quiet();
        s_rst = 0; s_fin = 0; s_rs = 0; s_vs = 0;
        rand_pix();
    endtask

    // Scoreboard monitor
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_rgb",      {bus.o_red, bus.o_green, bus.o_blue}, e.rgb);
            chk("sb_finished", 24'(bus.o_finished), 24'(e.fin));
            chk("sb_label_on", 24'(bus.o_label_on), 24'(e.lab));
        end
    end

    task automatic do_reset();
        quiet();
        s_rst = 1;
        repeat (3) begin rand_pix(); s_fin = 1'($urandom); s_rs = 1'($urandom); apply(); end
        @(posedge clk); #2;
        chk("reset_rgb", {bus.o_red, bus.o_green, bus.o_blue}, 24'h0);
        chk("reset_flags", {22'd0, bus.o_finished, bus.o_label_on}, 24'h0);
        quiet();
    endtask

    task automatic pixel(input logic [23:0] bg, input logic ghit, input logic lhit, input logic de);
        s_bg = bg; s_game = 24'h808080; s_label = 24'h0000FF;
        s_ghit = ghit; s_lhit = lhit; s_de = de;
    endtask

    task automatic ticks(input int n, inout int toggles, inout int last_tog, inout logic prev);
        for (int t = 1; t <= n; t++) begin
            for (int c = 0; c < 4; c++) begin
                rand_pix();
                s_vs = (c < 2);
                apply();
                @(posedge clk); #2;
                if (bus.o_label_on !== prev) begin
                    toggles++;
                    last_tog = t;
                end
                prev = bus.o_label_on;
            end
        end
    endtask

    initial begin
        int   toggles, last_tog;
        logic prev;
        m_fin = 0; m_ticks = 0; m_vsq = 0;
        bus.i_v_sync = 0; bus.i_de = 0; bus.i_game_hit = 0; bus.i_label_hit = 0;
        bus.i_finish = 0; bus.i_restart = 0;
        {bus.i_bg_red, bus.i_bg_green, bus.i_bg_blue} = 24'h0;
        {bus.i_game_red, bus.i_game_green, bus.i_game_blue} = 24'h0;
        {bus.i_label_red, bus.i_label_green, bus.i_label_blue} = 24'h0;

        do_reset();

        // Priority while playing: label hidden
        pixel(24'h102030, 1, 1, 1); apply(); @(posedge clk); #2;
        chk("play_game", {bus.o_red, bus.o_green, bus.o_blue}, 24'h808080);
        pixel(24'h102030, 0, 1, 1); apply(); @(posedge clk); #2;
        chk("play_bg", {bus.o_red, bus.o_green, bus.o_blue}, 24'h102030);
        pixel(24'h102030, 1, 1, 0); apply(); @(posedge clk); #2;
        chk("play_blank", {bus.o_red, bus.o_green, bus.o_blue}, 24'h000000);

        // Finish pulse
        pixel(24'h102030, 0, 0, 1); s_fin = 1; apply(); @(posedge clk); #2;
        chk("fin_flags", {22'd0, bus.o_finished, bus.o_label_on}, 24'h3);
        s_fin = 0;
        pixel(24'h102030, 1, 1, 1); apply(); @(posedge clk); #2;
        chk("fin_label", {bus.o_red, bus.o_green, bus.o_blue}, 24'h0000FF);
        pixel(24'h102030, 0, 0, 1); apply(); @(posedge clk); #2;
        chk("fin_dim_bg", {bus.o_red, bus.o_green, bus.o_blue}, 24'h081018);

        // Blink through 60 frame ticks
        toggles = 0; last_tog = 0; prev = 1'b1;
        ticks(60, toggles, last_tog, prev);
        chk("blink_toggles", 24'(toggles), 24'(BT));
        chk("blink_last_tick", 24'(last_tog), 24'(BF * BT));
        chk("hold_flags", {22'd0, bus.o_finished, bus.o_label_on}, 24'h3);

        // Restart mid-blink with simultaneous finish
        do_reset();
        quiet(); s_fin = 1; apply();
        toggles = 0; last_tog = 0; prev = 1'b1;
        ticks(11, toggles, last_tog, prev);
        quiet(); s_rs = 1; s_fin = 1; apply(); @(posedge clk); #2;
        chk("restart_flags", {22'd0, bus.o_finished, bus.o_label_on}, 24'h0);
        quiet(); pixel(24'h102030, 0, 1, 1); apply(); @(posedge clk); #2;
        chk("restart_undim", {bus.o_red, bus.o_green, bus.o_blue}, 24'h102030);

        // Unselected sources carry junk; output must equal background
        for (int i = 0; i < 20; i++) begin
            quiet(); s_de = 1; s_ghit = 0; s_lhit = 0; apply();
        end

        // Random soak
        for (int i = 0; i < 3000; i++) begin
            rand_pix();
            s_rst = ($urandom % 400) == 0;
            s_fin = ($urandom % 40) == 0;
            s_rs  = ($urandom % 500) == 0;
            s_vs  = ($urandom % 3) == 0;
            apply();
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 24'(q.size()), 24'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
